pong_scoreboard: RTL and testbench



---
 rtl/pong_pkg.sv | 27 ++
 rtl/bcd2_counter.sv | 60 ++++++
 rtl/pong_scoreboard.sv | 150 +++++++++++++++
 tb/tb_pong_scoreboard.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared types and constants for the LED Pong scoreboard.
//                Contents: the game state encoding, the winner codes and the
//                width of one BCD digit.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

   // Width of one BCD digit.
   localparam int BCD_W = 4;

   // Game state encoding.
   typedef enum logic [0:0] {
      ST_PLAY = 1'b0,
      ST_OVER = 1'b1
   } state_t;

   // Winner codes, as they appear on the winner output.
   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/bcd2_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd2_counter
//  Description : Two-digit BCD up counter. It has a synchronous clear and an
//                increment input. It also outputs the value the counter would
//                hold after an increment, so the caller can check for a win
//                on the new score without waiting one cycle.
//  Ports       : clk, rst (async, active-high)
//                inc       - add one on this edge
//                clr       - synchronous clear to 00; overrides inc
//                tens/ones - registered count
//                nxt_tens/nxt_ones - count after an increment (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd2_counter
   import pong_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic [BCD_W-1:0] nxt_tens,
   output logic [BCD_W-1:0] nxt_ones
);

   logic [BCD_W-1:0] r_tens;
   logic [BCD_W-1:0] r_ones;

   // Incremented value. The tens digit wraps 9 -> 0 only so that every
   // value stays valid BCD. The caller stops counting at the winning score,
   // so this wrap never happens in use.
   always_comb begin
      nxt_tens = r_tens;
      nxt_ones = r_ones + 4'd1;
      if (r_ones == 4'd9) begin
         nxt_ones = 4'd0;
         nxt_tens = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tens <= '0;
         r_ones <= '0;
      end else if (clr) begin
         r_tens <= '0;
         r_ones <= '0;
      end else if (inc) begin
         r_tens <= nxt_tens;
         r_ones <= nxt_ones;
      end
   end

   assign tens = r_tens;
   assign ones = r_ones;

endmodule : bcd2_counter
`default_nettype wire

// File: rtl/pong_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : pong_scoreboard
//  Description : Score keeper for LED Pong. It detects rising edges on the
//                point inputs, keeps a two-digit BCD score for each player,
//                detects the winning score and freezes play at game over.
//  Ports       : clk, rst (async, active-high)
//                p1_point, p2_point - scoring levels from game logic
//                new_game           - level-sensitive clear and restart
//                dig3/dig2          - P1 tens/ones (BCD)
//                dig1/dig0          - P2 tens/ones (BCD)
//                game_over          - high in the OVER state
//                winner             - 00 none, 01 P1, 10 P2, 11 draw
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_scoreboard
   import pong_pkg::*;
#(
   parameter int WIN_SCORE = 11
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             p1_point,
   input  logic             p2_point,
   input  logic             new_game,
   output logic [BCD_W-1:0] dig3,
   output logic [BCD_W-1:0] dig2,
   output logic [BCD_W-1:0] dig1,
   output logic [BCD_W-1:0] dig0,
   output logic             game_over,
   output logic [1:0]       winner
);

   localparam logic [BCD_W-1:0] c_win_tens = BCD_W'(WIN_SCORE / 10);
   localparam logic [BCD_W-1:0] c_win_ones = BCD_W'(WIN_SCORE % 10);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [1:0]       r_winner;
   logic [1:0]       w_winner_nxt;
   logic             r_p1_q;
   logic             r_p2_q;

   logic             w_p1_ev;
   logic             w_p2_ev;
   logic             w_p1_inc;
   logic             w_p2_inc;
   logic             w_p1_hit;
   logic             w_p2_hit;

   logic [BCD_W-1:0] w_p1_nxt_tens;
   logic [BCD_W-1:0] w_p1_nxt_ones;
   logic [BCD_W-1:0] w_p2_nxt_tens;
   logic [BCD_W-1:0] w_p2_nxt_ones;

   // The edge registers follow the inputs in every cycle. This includes
   // cycles where new_game discards the event, so a level that stays high
   // after new_game does not count later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p1_q <= 1'b0;
         r_p2_q <= 1'b0;
      end else begin
         r_p1_q <= p1_point;
         r_p2_q <= p2_point;
      end
   end

   assign w_p1_ev  = p1_point & ~r_p1_q;
   assign w_p2_ev  = p2_point & ~r_p2_q;

   // Counting happens only in PLAY. new_game overrides any point event in
   // the same cycle.
   assign w_p1_inc = w_p1_ev & (r_state == ST_PLAY) & ~new_game;
   assign w_p2_inc = w_p2_ev & (r_state == ST_PLAY) & ~new_game;

   bcd2_counter u_p1_score (
      .clk      (clk),
      .rst      (rst),
      .inc      (w_p1_inc),
      .clr      (new_game),
      .tens     (dig3),
      .ones     (dig2),
      .nxt_tens (w_p1_nxt_tens),
      .nxt_ones (w_p1_nxt_ones)
   );

   bcd2_counter u_p2_score (
      .clk      (clk),
      .rst      (rst),
      .inc      (w_p2_inc),
      .clr      (new_game),
      .tens     (dig1),
      .ones     (dig0),
      .nxt_tens (w_p2_nxt_tens),
      .nxt_ones (w_p2_nxt_ones)
   );

   // The win check uses the score after the increment. Scores move up one
   // at a time from 00, so an equality test is enough. The winner is then
   // registered on the same edge as the winning digit.
   assign w_p1_hit = w_p1_inc && (w_p1_nxt_tens == c_win_tens) && (w_p1_nxt_ones == c_win_ones);
   assign w_p2_hit = w_p2_inc && (w_p2_nxt_tens == c_win_tens) && (w_p2_nxt_ones == c_win_ones);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_PLAY;
         r_winner <= WIN_NONE;
      end else begin
         r_state  <= w_state_nxt;
         r_winner <= w_winner_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_winner_nxt = r_winner;
      if (new_game) begin
         w_state_nxt  = ST_PLAY;
         w_winner_nxt = WIN_NONE;
      end else begin
         case (r_state)
            ST_PLAY: begin
               if (w_p1_hit && w_p2_hit) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = WIN_DRAW;
               end else if (w_p1_hit) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = WIN_P1;
               end else if (w_p2_hit) begin
                  w_state_nxt  = ST_OVER;
                  w_winner_nxt = WIN_P2;
               end
            end
            ST_OVER: begin
               w_state_nxt = ST_OVER;
            end
            default: begin
               w_state_nxt  = ST_PLAY;
               w_winner_nxt = WIN_NONE;
            end
         endcase
      end
   end

   assign game_over = (r_state == ST_OVER);
   assign winner    = r_winner;

endmodule : pong_scoreboard
`default_nettype wire

// File: tb/tb_pong_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_scoreboard
//  Description : Directed testbench for pong_scoreboard with WIN_SCORE = 11.
//                Inputs change on the falling edge and outputs are sampled
//                on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pong_scoreboard;

   logic       clk;
   logic       rst;
   logic       p1_point;
   logic       p2_point;
   logic       new_game;
   logic [3:0] dig3, dig2, dig1, dig0;
   logic       game_over;
   logic [1:0] winner;

   int n_pass;
   int n_total;

   pong_scoreboard #(.WIN_SCORE(11)) dut (
      .clk       (clk),
      .rst       (rst),
      .p1_point  (p1_point),
      .p2_point  (p2_point),
      .new_game  (new_game),
      .dig3      (dig3),
      .dig2      (dig2),
      .dig1      (dig1),
      .dig0      (dig0),
      .game_over (game_over),
      .winner    (winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive a one-cycle rise on the chosen inputs, then one low cycle.
   // Call this at a falling edge. It returns at a falling edge.
   task automatic pulse(input logic a, input logic b);
      p1_point = a;
      p2_point = b;
      @(negedge clk);
      p1_point = 1'b0;
      p2_point = 1'b0;
      @(negedge clk);
   endtask

   task automatic clear_game();
      new_game = 1'b1;
      @(negedge clk);
      new_game = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; p1_point = 1'b0; p2_point = 1'b0; new_game = 1'b0;
      @(negedge clk);
      n_total++;
      if ({dig3, dig2, dig1, dig0} !== 16'h0000) $display("FAIL reset_digits: got %h expected 0000", {dig3, dig2, dig1, dig0});
      else n_pass++;
      n_total++;
      if ({game_over, winner} !== 3'b000) $display("FAIL reset_status: got go=%b win=%b expected go=0 win=00", game_over, winner);
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_p1_single();
      p1_point = 1'b1;
      @(negedge clk);
      n_total++;
      if ({dig3, dig2, dig1, dig0} !== 16'h0100) $display("FAIL p1_first_edge: got %h expected 0100", {dig3, dig2, dig1, dig0});
      else n_pass++;
      repeat (2) @(negedge clk);
      n_total++;
      if ({dig3, dig2, dig1, dig0} !== 16'h0100) $display("FAIL p1_held_once: got %h expected 0100", {dig3, dig2, dig1, dig0});
      else n_pass++;
      p1_point = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_p2_tens();
      repeat (9) pulse(1'b0, 1'b1);
      n_total++;
      if ({dig1, dig0} !== 8'h09) $display("FAIL p2_nine: got %h expected 09", {dig1, dig0});
      else n_pass++;
      pulse(1'b0, 1'b1);
      n_total++;
      if ({dig3, dig2, dig1, dig0} !== 16'h0110) $display("FAIL p2_carry: got %h expected 0110", {dig3, dig2, dig1, dig0});
      else n_pass++;
   endtask

   task automatic test_p1_win();
      repeat (9) pulse(1'b1, 1'b0);
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over} !== {16'h1010, 1'b0}) $display("FAIL p1_ten: got %h go=%b expected 1010 go=0", {dig3, dig2, dig1, dig0}, game_over);
      else n_pass++;
      p1_point = 1'b1;
      @(negedge clk);
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over, winner} !== {16'h1110, 1'b1, 2'b01}) $display("FAIL p1_win: got %h go=%b win=%b expected 1110 go=1 win=01", {dig3, dig2, dig1, dig0}, game_over, winner);
      else n_pass++;
      p1_point = 1'b0;
      @(negedge clk);
      pulse(1'b1, 1'b1);
      pulse(1'b0, 1'b1);
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over, winner} !== {16'h1110, 1'b1, 2'b01}) $display("FAIL over_frozen: got %h go=%b win=%b expected 1110 go=1 win=01", {dig3, dig2, dig1, dig0}, game_over, winner);
      else n_pass++;
   endtask

   task automatic test_new_game_priority();
      new_game = 1'b1;
      p2_point = 1'b1;
      @(negedge clk);
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over, winner} !== {16'h0000, 1'b0, 2'b00}) $display("FAIL new_game_clear: got %h go=%b win=%b expected 0000 go=0 win=00", {dig3, dig2, dig1, dig0}, game_over, winner);
      else n_pass++;
      new_game = 1'b0;
      @(negedge clk);
      n_total++;
      if ({dig1, dig0} !== 8'h00) $display("FAIL new_game_discard: got %h expected 00", {dig1, dig0});
      else n_pass++;
      p2_point = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_draw();
      repeat (10) pulse(1'b1, 1'b1);
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over} !== {16'h1010, 1'b0}) $display("FAIL draw_ten: got %h go=%b expected 1010 go=0", {dig3, dig2, dig1, dig0}, game_over);
      else n_pass++;
      pulse(1'b1, 1'b1);
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over, winner} !== {16'h1111, 1'b1, 2'b11}) $display("FAIL draw_win: got %h go=%b win=%b expected 1111 go=1 win=11", {dig3, dig2, dig1, dig0}, game_over, winner);
      else n_pass++;
   endtask

   task automatic test_p2_win();
      clear_game();
      repeat (11) pulse(1'b0, 1'b1);
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over, winner} !== {16'h0011, 1'b1, 2'b10}) $display("FAIL p2_win: got %h go=%b win=%b expected 0011 go=1 win=10", {dig3, dig2, dig1, dig0}, game_over, winner);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      clear_game();
      repeat (5) pulse(1'b1, 1'b1);
      repeat (2) pulse(1'b1, 1'b0);
      n_total++;
      if ({dig3, dig2, dig1, dig0} !== 16'h0705) $display("FAIL pre_reset_score: got %h expected 0705", {dig3, dig2, dig1, dig0});
      else n_pass++;
      #2 rst = 1'b1;
      p1_point = 1'b1;
      #1;
      n_total++;
      if ({dig3, dig2, dig1, dig0, game_over, winner} !== {16'h0000, 1'b0, 2'b00}) $display("FAIL async_reset: got %h go=%b win=%b expected 0000 go=0 win=00", {dig3, dig2, dig1, dig0}, game_over, winner);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      // P1 is already high when reset is released, so it counts as a point.
      @(negedge clk);
      n_total++;
      if ({dig3, dig2, dig1, dig0} !== 16'h0100) $display("FAIL high_at_release: got %h expected 0100", {dig3, dig2, dig1, dig0});
      else n_pass++;
      p1_point = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      n_pass  = 0;
      n_total = 0;
      test_reset();
      test_p1_single();
      test_p2_tens();
      test_p1_win();
      test_new_game_priority();
      test_draw();
      test_p2_win();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_pong_scoreboard
`default_nettype wire
